// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_mul(input logic [2:0] f3);
        return (f3[2] == 1'b0);
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return ((f3 == F3_REM) || (f3 == F3_REMU));
    endfunction

    function automatic logic a_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
            default:                            s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic b_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MULH, F3_DIV, F3_REM: s = 1'b1;
            default:                 s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the decode/register stage and muldiv_iter.
interface muldiv_iter_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, op_a, op_b, input busy, done, result);
    modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_signconv.sv
// Sign/magnitude helper: abs mode strips the sign of a (possibly signed) value,
// neg mode conditionally applies two's-complement negation to a magnitude.
module muldiv_signconv #(
    parameter int W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         signed_i,
    input  logic         neg_sel_i,
    output logic [W-1:0] mag_o,
    output logic         negative_o
);

    // Decide whether to negate, then produce the converted value.
    always_comb begin
        if (neg_sel_i) begin
            negative_o = signed_i;
        end else begin
            negative_o = signed_i & value_i[W-1];
        end
        if (negative_o) begin
            mag_o = ~value_i + {{(W-1){1'b0}}, 1'b1};
        end else begin
            mag_o = value_i;
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, fixed latency for every operation.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_iter_if.slave bus
);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              prep_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   mag_a_q, mag_b_q, raw_a_q;
    logic              neg_a_q, neg_b_q, b_zero_q, ovf_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic              neg_a_s, neg_b_s;
    logic [XLEN:0]     sum_s, rsh_s, diff_s;
    logic [XLEN-1:0]   div_val_s;
    logic              div_neg_s;
    logic [2*XLEN-1:0] fin_val_s, fin_mag_s;
    logic              fin_neg_s, fin_sign_unused_s;

    muldiv_signconv #(.W(XLEN)) u_conv_a (
        .value_i    (bus.op_a),
        .signed_i   (a_signed(bus.funct3)),
        .neg_sel_i  (1'b0),
        .mag_o      (mag_a_s),
        .negative_o (neg_a_s)
    );

    muldiv_signconv #(.W(XLEN)) u_conv_b (
        .value_i    (bus.op_b),
        .signed_i   (b_signed(bus.funct3)),
        .neg_sel_i  (1'b0),
        .mag_o      (mag_b_s),
        .negative_o (neg_b_s)
    );

    muldiv_signconv #(.W(2*XLEN)) u_conv_fin (
        .value_i    (fin_val_s),
        .signed_i   (fin_neg_s),
        .neg_sel_i  (1'b1),
        .mag_o      (fin_mag_s),
        .negative_o (fin_sign_unused_s)
    );

    // One iteration: multiply keeps {hi, multiplier}, divide keeps {remainder, quotient}.
    always_comb begin
        sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                 (acc_q[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});
        rsh_s  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff_s = rsh_s - {1'b0, mag_b_q};
        if (is_mul(f3_q)) begin
            acc_d = {sum_s, acc_q[XLEN-1:1]};
        end else if (!diff_s[XLEN]) begin
            acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = {rsh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    // Select what the final sign correction operates on.
    always_comb begin
        if (is_rem(f3_q)) begin
            div_val_s = acc_d[2*XLEN-1:XLEN];
            div_neg_s = neg_a_q;
        end else begin
            div_val_s = acc_d[XLEN-1:0];
            div_neg_s = neg_a_q ^ neg_b_q;
        end
        if (is_mul(f3_q)) begin
            fin_val_s = acc_d;
            fin_neg_s = neg_a_q ^ neg_b_q;
        end else begin
            fin_val_s = {{XLEN{1'b0}}, div_val_s};
            fin_neg_s = div_neg_s;
        end
    end

    // Final result with divide-by-zero and signed-overflow overrides.
    always_comb begin
        result_d = {XLEN{1'b0}};
        case (f3_q)
            F3_MUL:                       result_d = fin_mag_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = fin_mag_s[2*XLEN-1:XLEN];
            F3_DIV: begin
                if (b_zero_q)   result_d = ALL_ONES;
                else if (ovf_q) result_d = MIN_NEG;
                else            result_d = fin_mag_s[XLEN-1:0];
            end
            F3_DIVU: begin
                if (b_zero_q) result_d = ALL_ONES;
                else          result_d = fin_mag_s[XLEN-1:0];
            end
            F3_REM: begin
                if (b_zero_q)   result_d = raw_a_q;
                else if (ovf_q) result_d = {XLEN{1'b0}};
                else            result_d = fin_mag_s[XLEN-1:0];
            end
            F3_REMU: begin
                if (b_zero_q) result_d = raw_a_q;
                else          result_d = fin_mag_s[XLEN-1:0];
            end
            default: result_d = {XLEN{1'b0}};
        endcase
    end

    // Control FSM, operand capture, iteration counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            prep_q   <= 1'b0;
            f3_q     <= 3'd0;
            mag_a_q  <= {XLEN{1'b0}};
            mag_b_q  <= {XLEN{1'b0}};
            raw_a_q  <= {XLEN{1'b0}};
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= {(2*XLEN){1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {XLEN{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q  <= ST_RUN;
                        cnt_q    <= {CNT_W{1'b0}};
                        prep_q   <= 1'b1;
                        f3_q     <= bus.funct3;
                        mag_a_q  <= mag_a_s;
                        mag_b_q  <= mag_b_s;
                        raw_a_q  <= bus.op_a;
                        neg_a_q  <= neg_a_s;
                        neg_b_q  <= neg_b_s;
                        b_zero_q <= (bus.op_b == {XLEN{1'b0}});
                        ovf_q    <= (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONES);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // The first RUN cycle seeds the working register from the captured magnitudes.
                    if (prep_q) begin
                        prep_q <= 1'b0;
                        busy_q <= 1'b1;
                        acc_q  <= is_mul(f3_q) ? {{XLEN{1'b0}}, mag_b_q}
                                               : {{XLEN{1'b0}}, mag_a_q};
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_q == CNT_W'(XLEN-1)) begin
                            state_q  <= ST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= result_d;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: arithmetic reference model plus a
// cycle-level expectation of busy/done/result compared on every falling edge.
module tb_muldiv_iter;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    muldiv_iter_if #(.XLEN(32)) bus ();

    muldiv_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 32'd0;
        case (f3)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle-level expectation: an op accepted at edge t0 shows busy on t0+1..t0+32,
    // done and its result on t0+33, and the unit accepts again from edge t0+34.
    int          t0      = -1;
    logic [31:0] pend_res = 32'd0;
    logic [31:0] exp_res  = 32'd0;
    bit          chk_en   = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            t0      = -1;
            exp_res = 32'd0;
            chk_en  = 1'b1;
        end else begin
            if (t0 >= 0 && cyc == t0 + 33) exp_res = pend_res;
            if (bus.start === 1'b1 && (t0 < 0 || cyc >= t0 + 34)) begin
                t0       = cyc;
                pend_res = ref_op(bus.funct3, bus.op_a, bus.op_b);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("busy",   {31'd0, bus.busy}, {31'd0, (t0 >= 0 && cyc >= t0 + 1 && cyc <= t0 + 32)});
            check("done",   {31'd0, bus.done}, {31'd0, (t0 >= 0 && cyc == t0 + 33)});
            check("result_trace", bus.result, exp_res);
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Wait for done (bounded); optionally scribble on the inputs meanwhile.
    task automatic wait_done(input bit noise, output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) nbusy++;
            if (noise) begin
                bus.start  = 1'($urandom_range(0, 1));
                bus.funct3 = 3'($urandom_range(0, 7));
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: actual=no done required=done within 40 cycles");
        end
    endtask

    task automatic run_dir(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int lat, nb;
        check({name, "_model"}, ref_op(f3, a, b), exp);
        issue(f3, a, b);
        wait_done(1'b1, lat, nb);
        check({name, "_latency"}, 32'(lat), 32'd33);
        check({name, "_busy_cycles"}, 32'(nb), 32'd32);
        check(name, bus.result, exp);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int lat, nb, ndone;
        logic [2:0]  f3;
        logic [31:0] a, b;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'd0, bus.busy}, 32'd0);
        check("reset_done",   {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst_n = 1'b1;

        run_dir("mul_neg_low",   F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_dir("mulh_minmin",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_dir("mulhu_ones",    F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_dir("mulhsu_ones",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_dir("div_m7_2",      F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        run_dir("rem_m7_2",      F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        run_dir("divu_100_7",    F3_DIVU,   32'd100,       32'd7,         32'd14);
        run_dir("remu_100_7",    F3_REMU,   32'd100,       32'd7,         32'd2);
        run_dir("div_by_zero",   F3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF);
        run_dir("divu_by_zero",  F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
        run_dir("rem_by_zero",   F3_REM,    32'd5,         32'd0,         32'd5);
        run_dir("div_overflow",  F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_dir("rem_overflow",  F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // start and operand changes during RUN must be ignored
        issue(F3_DIVU, 32'd1000, 32'd7);
        repeat (5) @(negedge clk);
        bus.start  = 1'b1;
        bus.op_a   = 32'd5;
        bus.funct3 = F3_MUL;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(1'b0, lat, nb);
        check("ignore_start_latency", 32'(lat), 32'd27);
        check("ignore_start_result", bus.result, 32'd142);

        // reset in the middle of an operation
        issue(F3_MUL, 32'h1234_5678, 32'd3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_busy",   {31'd0, bus.busy}, 32'd0);
        check("midreset_done",   {31'd0, bus.done}, 32'd0);
        check("midreset_result", bus.result, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("midreset_no_done", 32'(ndone), 32'd0);
        run_dir("mul_after_reset", F3_MUL, 32'd3, 32'd4, 32'd12);

        // back-to-back: new op accepted in the DONE cycle
        issue(F3_MUL, 32'd6, 32'd7);
        wait_done(1'b0, lat, nb);
        check("b2b_first_result", bus.result, 32'd42);
        bus.start  = 1'b1;
        bus.funct3 = F3_DIVU;
        bus.op_a   = 32'd9;
        bus.op_b   = 32'd3;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done(1'b0, lat, nb);
        check("b2b_latency", 32'(lat), 32'd33);
        check("b2b_second_result", bus.result, 32'd3);

        // randomized operations with input noise during RUN
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(f3, a, b);
            wait_done(1'b1, lat, nb);
            check("rand_latency", 32'(lat), 32'd33);
            check("rand_result", bus.result, ref_op(f3, a, b));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=still running required=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide unit, directly downstream of the register bank.
- Consumes the two read-port operands (rd1 → op_a, rd2 → op_b) and funct3 from the decoder.
- Returns a 32-bit result to the write-back mux (wd3 path) after a fixed latency.
- The control unit stalls the PC while busy is high; done gates we for the destination register.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width, clog2(XLEN).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (rd1).
- op_b  in  XLEN  rs2 value (rd2).
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  result, held until the next accepted start.

Behaviour:
- Single clock domain: clk only.
- Reset: synchronous, active-low, on rst_n. When rst_n is low at a rising edge:
  - state → IDLE;
  - busy=0, done=0, result=0;
  - counter and internal registers cleared.
  - Applies mid-operation too: the in-flight op is discarded and no done is issued.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1, latch funct3/op_a/op_b, compute operand magnitudes and sign flags, counter=0, go to RUN.
  - RUN: busy=1. One iteration per cycle. After the iteration with counter=XLEN-1, go to DONE.
  - DONE: done=1, busy=0, result register updated on entry. If start=1, accept the new op (same as IDLE) and go to RUN; else go to IDLE.
- Latency: fixed for all ops and operand values, including divide-by-zero.
  - start sampled at edge T0 → done high in the cycle after edge T0+XLEN+1 (33 cycles at XLEN=32).
  - No early-out.
- Start handling:
  - start during RUN is ignored; no queueing.
  - op_a/op_b/funct3 changes after acceptance have no effect.
- Multiply: shift-add on magnitudes, 2*XLEN-bit product register.
  - Signedness:
    - MULH: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU and MUL: both unsigned (MUL low half is sign-agnostic).
  - Final product negated if exactly one signed operand was negative.
  - MUL returns bits [XLEN-1:0]; the others return [2*XLEN-1:XLEN].
- Divide: restoring, one quotient bit per cycle, on magnitudes.
  - DIV/REM signed; DIVU/REMU unsigned.
  - Quotient negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Special cases (RISC-V spec), applied when computing result on entry to DONE:
  - op_b=0: DIV/DIVU → all ones; REM/REMU → op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- All arithmetic is modulo 2^XLEN (or 2^(2*XLEN) internally). Negation is two's complement.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams (F3_MUL … F3_REMU);
  - state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - XLEN default.
- One sub-module, muldiv_signconv (combinational): takes value plus signed flag, returns magnitude and negative flag. Instanced for op_a and op_b at acceptance, and reused with an abs→neg select for final correction.
- FSM, counter and datapath stay in muldiv_iter.

Test Plan:
- Multiply, signed low: MUL op_a=7, op_b=0xFFFFFFFD → result 0xFFFFFFEB. done exactly 33 cycles after start; busy high for 32 cycles.
- High-half multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide/remainder:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF; DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - All ops still take 33 cycles.
- Robustness:
  - start pulsed at cycle 5 of RUN, op_a changed mid-op → ignored; original result unchanged.
  - rst_n low at cycle 10 → next edge busy=0, done=0, result=0, no done pulse.
  - Fresh MUL 3×4 afterwards → 12.
- Back-to-back: start held high in the DONE cycle with DIVU 9/3 → previous result shown with done, new op accepted, result 3 after 33 further cycles.
